jts16_memmap: RTL and testbench

- Parametrised successor of the S16B 315-5195 memory mapper with NREG programmable address regions.
- Each region has a base address, a size, and a wait-state setting. The block provides 68000 DTACK generation with a real wait-state counter, a VBLANK interrupt with acknowledge, and a FIFO-buffered main-to-sound command latch in place of the single-byte latch.
- Sits between the 68000 bus and the board chip selects. It owns the region-decode `active` vector and the Z80 command path.

---
 rtl/jts16_memmap_if.sv | 23 ++
 rtl/jts16_memmap.sv | 170 +++++++++++++++++
 tb/tb_jts16_memmap.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jts16_memmap_if.sv
// 68000-side bus bundle for the jts16_memmap block: address/data/strobes in,
// DTACK and interrupt signalling back to the CPU.
interface jts16_memmap_if;
  logic [23:1] addr;
  logic [15:0] cpu_dout;
  logic [1:0]  cpu_dswn;
  logic        cpu_asn;
  logic [2:0]  cpu_fc;
  logic        edackn;
  logic        cpu_dtackn;
  logic [2:0]  cpu_ipln;
  logic        cpu_vpan;

  modport master (
    output addr, cpu_dout, cpu_dswn, cpu_asn, cpu_fc, edackn,
    input  cpu_dtackn, cpu_ipln, cpu_vpan
  );

  modport slave (
    input  addr, cpu_dout, cpu_dswn, cpu_asn, cpu_fc, edackn,
    output cpu_dtackn, cpu_ipln, cpu_vpan
  );
endinterface

// File: rtl/jts16_memmap.sv
// Programmable S16B-style memory mapper: NREG decoded regions with wait states,
// DTACK generation, VBLANK interrupt and a FIFO main-to-sound command path.
module jts16_memmap #(
  parameter int NREG       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IRQ_LVL    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_cen,
  jts16_memmap_if.slave   bus,
  output logic [NREG-1:0] o_active,
  input  logic            i_vint,
  input  logic            i_snd_rd,
  output logic [7:0]      o_snd_dout,
  output logic            o_snd_obf,
  output logic            o_snd_full,
  input  logic [7:0]      i_st_addr,
  output logic [7:0]      o_st_dout
);
  localparam int RW   = $clog2(NREG) + 2;
  localparam int NMMR = 2**RW;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;

  logic [7:0]      r_mmr [NMMR];
  logic            r_written;
  logic [1:0]      r_cnt;
  logic            r_dtackn;
  logic            r_vint_d;
  logic            r_pend;
  logic [7:0]      r_fifo [FIFO_DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_fcnt;
  logic            r_ovf;
  logic            r_obf;
  logic            r_full;
  logic [7:0]      r_st_dout;

  logic [NREG-1:0] w_match;
  logic [NREG-1:0] w_active;
  logic [1:0]      w_wsel [NREG];
  logic [1:0]      w_wait;
  logic            w_iack;
  logic            w_we;
  logic [RW-1:0]   w_idx;
  logic            w_push;
  logic            w_pop;
  logic            w_push_ok;
  logic [CW-1:0]   w_fcnt_nx;
  logic [1:0]      w_cnt_nx;
  logic            w_dtack_ok;
  logic            w_unused_bits;

  function automatic logic f_match(input logic [7:0] hi, input logic [7:0] ctrl,
                                   input logic [7:0] base);
    case (ctrl[1:0])
      2'd0:    return hi[7:0] == base[7:0];
      2'd1:    return hi[7:1] == base[7:1];
      2'd2:    return hi[7:3] == base[7:3];
      default: return hi[7:5] == base[7:5];
    endcase
  endfunction

  // Region r owns control at {1,r,0} and base at {1,r,1}
  for (genvar g = 0; g < NREG; g++) begin : g_region
    assign w_match[g] = f_match(bus.addr[23:16], r_mmr[NMMR/2 + 2*g], r_mmr[NMMR/2 + 2*g + 1]);
    assign w_wsel[g]  = w_active[g] ? r_mmr[NMMR/2 + 2*g][3:2] : 2'd0;
  end

  assign w_iack   = (bus.cpu_fc == 3'd7);
  assign w_active = w_iack ? '0 : (w_match & (~w_match + NREG'(1)));
  assign o_active = w_active;

  always_comb begin
    w_wait = 2'd0;
    for (int r = 0; r < NREG; r++) w_wait = w_wait | w_wsel[r];
  end

  assign w_idx  = bus.addr[RW:1];
  assign w_we   = ~bus.cpu_asn & ~bus.cpu_dswn[0] & ~|w_active & ~w_iack & ~r_written;
  assign w_push = w_we & (w_idx == RW'(3));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NMMR; i++) r_mmr[i] <= 8'd0;
      r_written <= 1'b0;
    end else begin
      if (w_we) r_mmr[w_idx] <= bus.cpu_dout[7:0];
      if (bus.cpu_asn)  r_written <= 1'b0;
      else if (w_we)    r_written <= 1'b1;
    end
  end

  // Sound FIFO: a pop frees a slot for a same-cycle push even when full
  assign w_pop     = i_snd_rd & (r_fcnt != '0);
  assign w_push_ok = w_push & ((r_fcnt != CW'(FIFO_DEPTH)) | w_pop);
  assign w_fcnt_nx = r_fcnt + CW'(w_push_ok) - CW'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fcnt <= '0;
      r_ovf  <= 1'b0;
      r_obf  <= 1'b0;
      r_full <= 1'b0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + PW'(1);
      if (w_pop)     r_rd <= r_rd + PW'(1);
      if (w_push & ~w_push_ok) r_ovf <= 1'b1;
      r_fcnt <= w_fcnt_nx;
      r_obf  <= (w_fcnt_nx != '0);
      r_full <= (w_fcnt_nx == CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr] <= bus.cpu_dout[7:0];
  end

  assign o_snd_dout = (r_fcnt != '0) ? r_fifo[r_rd] : 8'd0;
  assign o_snd_obf  = r_obf;
  assign o_snd_full = r_full;

  // DTACK: count cen pulses while the strobe is low, release once wait is met
  assign w_cnt_nx   = (r_cnt == 2'd3) ? 2'd3 : r_cnt + 2'd1;
  assign w_dtack_ok = ({1'b0, w_cnt_nx} >= ({1'b0, w_wait} + 3'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 2'd0;
      r_dtackn <= 1'b1;
    end else if (bus.cpu_asn) begin
      r_cnt    <= 2'd0;
      r_dtackn <= 1'b1;
    end else if (!w_iack && i_cen) begin
      r_cnt <= w_cnt_nx;
      if (w_wait == 2'd3)  r_dtackn <= bus.edackn;
      else if (w_dtack_ok) r_dtackn <= 1'b0;
    end
  end

  assign bus.cpu_dtackn = r_dtackn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vint_d <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_vint_d <= i_vint;
      if (w_iack && !bus.cpu_asn)   r_pend <= 1'b0;
      else if (i_vint && !r_vint_d) r_pend <= 1'b1;
    end
  end

  assign bus.cpu_ipln = r_pend ? ~3'(IRQ_LVL) : 3'd7;
  assign bus.cpu_vpan = ~(w_iack & ~bus.cpu_asn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_st_dout <= 8'd0;
    else if (i_st_addr[7]) r_st_dout <= {r_ovf, 7'(r_fcnt)};
    else                   r_st_dout <= r_mmr[i_st_addr[RW-1:0]];
  end

  assign o_st_dout = r_st_dout;

  assign w_unused_bits = ^{bus.cpu_dout[15:8], bus.addr[15:RW+1], i_st_addr[6:RW]};
endmodule

// File: tb/tb_jts16_memmap.sv
// Directed and randomized bench for jts16_memmap against a byte-address-level
// model of the region map, DTACK latency, sound FIFO and VBLANK interrupt.
module tb_jts16_memmap;
  localparam int NREG = 8;
  localparam int FDEP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       vint = 1'b0;
  logic       snd_rd = 1'b0;
  logic [7:0] st_addr = 8'd0;
  logic [NREG-1:0] o_active;
  logic [7:0] snd_dout;
  logic       snd_obf;
  logic       snd_full;
  logic [7:0] st_dout;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_mmr [32];
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;

  always #5 clk = ~clk;

  jts16_memmap_if bus ();

  jts16_memmap #(.NREG(NREG), .FIFO_DEPTH(FDEP), .IRQ_LVL(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cen      (cen),
    .bus        (bus.slave),
    .o_active   (o_active),
    .i_vint     (vint),
    .i_snd_rd   (snd_rd),
    .o_snd_dout (snd_dout),
    .o_snd_obf  (snd_obf),
    .o_snd_full (snd_full),
    .i_st_addr  (st_addr),
    .o_st_dout  (st_dout)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.cpu_asn  = 1'b1;
    bus.cpu_dswn = 2'b11;
    bus.cpu_fc   = 3'd5;
    cen          = 1'b0;
  endtask

  task automatic set_addr(input int unsigned ba);
    bus.addr = ba[23:1];
  endtask

  function automatic int unsigned rbytes(input logic [1:0] s);
    case (s)
      2'd0:    return 32'h1_0000;
      2'd1:    return 32'h2_0000;
      2'd2:    return 32'h8_0000;
      default: return 32'h20_0000;
    endcase
  endfunction

  // Region r claims the aligned block of its size that contains base*64k
  function automatic logic [7:0] m_active(input int unsigned ba, input logic [2:0] fc);
    int unsigned rb;
    int unsigned bb;
    if (fc == 3'd7) return 8'd0;
    for (int r = 0; r < NREG; r++) begin
      rb = rbytes(m_mmr[16 + 2*r][1:0]);
      bb = m_mmr[17 + 2*r];
      if ((ba / rb) == ((bb * 32'h1_0000) / rb)) return 8'(1 << r);
    end
    return 8'd0;
  endfunction

  function automatic int m_wait(input int unsigned ba);
    logic [7:0] a;
    a = m_active(ba, 3'd5);
    for (int r = 0; r < NREG; r++)
      if (a[r]) return int'(m_mmr[16 + 2*r][3:2]);
    return 0;
  endfunction

  task automatic write_reg(input int idx, input logic [7:0] d, input bit pop_too);
    int unsigned ba;
    bit found;
    found = 1'b0;
    ba = 0;
    for (int h = 0; h < 256 && !found; h++)
      if (m_active(h << 16, 3'd5) == 8'd0) begin
        ba = h << 16;
        found = 1'b1;
      end
    if (!found) begin
      $display("FAIL write_reg: observed no unmapped address, required one");
      $fatal(1);
    end
    set_addr(ba | (idx << 1));
    bus.cpu_fc   = 3'd5;
    bus.cpu_dout = {8'hA5, d};
    bus.cpu_dswn = 2'b10;
    bus.cpu_asn  = 1'b0;
    snd_rd       = pop_too;
    tick;
    snd_rd = 1'b0;
    tick;
    tick;
    idle;
    tick;
    m_mmr[idx] = d;
    if (idx == 3) begin
      if (pop_too && q.size() > 0) void'(q.pop_front());
      if (q.size() < FDEP) q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic dtack_lat(input int unsigned ba, output int n, output logic [7:0] act);
    int c;
    c = 0;
    set_addr(ba);
    bus.cpu_fc   = 3'd5;
    bus.cpu_dswn = 2'b11;
    bus.cpu_asn  = 1'b0;
    cen          = 1'b0;
    #1 act = o_active;
    n = -1;
    for (int k = 0; k < 24; k++) begin
      cen = k[0];
      tick;
      if (cen) c++;
      if (bus.cpu_dtackn === 1'b0) begin
        n = c;
        break;
      end
    end
    idle;
    tick;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < FDEP; i++) begin
      chk(tag, snd_dout, q[0]);
      snd_rd = 1'b1;
      tick;
      snd_rd = 1'b0;
      void'(q.pop_front());
    end
  endtask

  initial begin
    int n;
    int unsigned ba;
    logic [7:0] act;
    logic [7:0] b;
    logic [7:0] base;
    int r;
    int sz;
    int w;
    bit any_low;

    idle;
    bus.addr     = '0;
    bus.cpu_dout = '0;
    bus.edackn   = 1'b1;
    for (int i = 0; i < 32; i++) m_mmr[i] = 8'd0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;

    chk("rst_dtackn", bus.cpu_dtackn, 1);
    chk("rst_ipln", bus.cpu_ipln, 7);
    chk("rst_vpan", bus.cpu_vpan, 1);
    chk("rst_obf", snd_obf, 0);
    chk("rst_full", snd_full, 0);
    chk("rst_sdout", snd_dout, 0);
    chk("rst_stdout", st_dout, 0);

    dtack_lat(32'h00_1000, n, act);
    chk("rst_active", act, m_active(32'h00_1000, 3'd5));
    chk("rst_dtack_lat", n, 1);

    // Region 0: wait mode 3 at 0x20xxxx, DTACK tracks edackn
    write_reg(16, 8'h0C, 1'b0);
    write_reg(17, 8'h20, 1'b0);
    set_addr(32'h20_1000);
    bus.cpu_dswn = 2'b11;
    bus.cpu_asn  = 1'b0;
    bus.edackn   = 1'b1;
    #1 chk("m3_active", o_active, m_active(32'h20_1000, 3'd5));
    any_low = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cen = k[0];
      tick;
      if (bus.cpu_dtackn !== 1'b1) any_low = 1'b1;
    end
    chk("m3_hold", any_low, 0);
    bus.edackn = 1'b0;
    cen = 1'b0;
    tick;
    chk("m3_nocen", bus.cpu_dtackn, 1);
    cen = 1'b1;
    tick;
    chk("m3_low", bus.cpu_dtackn, 0);
    bus.edackn = 1'b1;
    tick;
    chk("m3_follow", bus.cpu_dtackn, 1);
    idle;
    tick;

    dtack_lat(32'h00_1000, n, act);
    chk("low_active", act, m_active(32'h00_1000, 3'd5));
    chk("low_lat", n, m_wait(32'h00_1000) + 1);

    write_reg(18, 8'h08, 1'b0);
    write_reg(19, 8'h40, 1'b0);
    dtack_lat(32'h40_0000, n, act);
    chk("r1_active", act, m_active(32'h40_0000, 3'd5));
    chk("r1_lat", n, 3);
    write_reg(18, 8'h0B, 1'b0);
    dtack_lat(32'h5F_0000, n, act);
    chk("r1_big_active", act, m_active(32'h5F_0000, 3'd5));
    chk("r1_big_lat", n, 3);

    // Sound FIFO overflow and drain
    for (int i = 0; i < FDEP + 1; i++) write_reg(3, 8'($urandom), 1'b0);
    chk("fifo_full", snd_full, 1);
    chk("fifo_obf", snd_obf, 1);
    st_addr = 8'h80;
    tick;
    chk("fifo_stat", st_dout, {m_ovf, 7'(q.size())});
    st_addr = 8'h11;
    tick;
    chk("st_mmr", st_dout, m_mmr[17]);
    drain("fifo_order");
    chk("fifo_obf0", snd_obf, 0);
    chk("fifo_full0", snd_full, 0);
    chk("fifo_dout0", snd_dout, 0);
    snd_rd = 1'b1;
    tick;
    snd_rd = 1'b0;
    st_addr = 8'h80;
    tick;
    chk("fifo_empty_pop", st_dout, {m_ovf, 7'(q.size())});

    for (int i = 0; i < FDEP; i++) write_reg(3, 8'($urandom), 1'b0);
    write_reg(3, 8'($urandom), 1'b1);
    tick;
    chk("fifo_pp_full", snd_full, 1);
    chk("fifo_pp_stat", st_dout, {m_ovf, 7'(q.size())});
    drain("fifo_pp_order");

    // VBLANK interrupt and acknowledge
    vint = 1'b1;
    tick;
    chk("irq_ipln", bus.cpu_ipln, 3);
    chk("irq_vpan_idle", bus.cpu_vpan, 1);
    bus.cpu_fc  = 3'd7;
    bus.cpu_asn = 1'b0;
    #1 chk("iack_vpan", bus.cpu_vpan, 0);
    chk("iack_active", o_active, 0);
    any_low = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cen = k[0];
      tick;
      if (bus.cpu_dtackn !== 1'b1) any_low = 1'b1;
    end
    chk("iack_dtackn", any_low, 0);
    chk("iack_ipln", bus.cpu_ipln, 7);
    idle;
    repeat (4) tick;
    chk("irq_no_retrig", bus.cpu_ipln, 7);
    vint = 1'b0;
    tick;
    vint = 1'b1;
    bus.cpu_fc  = 3'd7;
    bus.cpu_asn = 1'b0;
    tick;
    idle;
    tick;
    chk("irq_clr_prio", bus.cpu_ipln, 7);

    // Randomized region programming against the byte-address model
    write_reg(16, 8'h00, 1'b0);
    for (int it = 0; it < 30; it++) begin
      r    = $urandom_range(0, NREG - 1);
      sz   = $urandom_range(0, 2);
      w    = $urandom_range(0, 2);
      base = 8'($urandom);
      write_reg(16 + 2*r, 8'((w << 2) | sz), 1'b0);
      write_reg(17 + 2*r, base, 1'b0);
      if ($urandom_range(0, 1) == 1) ba = (int'(base) << 16) + $urandom_range(0, 32'hFFFE);
      else ba = $urandom & 32'hFF_FFFE;
      dtack_lat(ba, n, act);
      chk("rnd_active", act, m_active(ba, 3'd5));
      chk("rnd_lat", n, m_wait(ba) + 1);
    end

    // Asynchronous reset in the middle of a clock period
    write_reg(3, 8'h5A, 1'b0);
    vint = 1'b0;
    tick;
    vint = 1'b1;
    tick;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) m_mmr[i] = 8'd0;
    q.delete();
    m_ovf = 1'b0;
    chk("arst_obf", snd_obf, 0);
    chk("arst_sdout", snd_dout, 0);
    chk("arst_ipln", bus.cpu_ipln, 7);
    chk("arst_stdout", st_dout, 0);
    set_addr(32'h00_1000);
    #1 chk("arst_active", o_active, m_active(32'h00_1000, 3'd5));
    tick;
    rst_n = 1'b1;
    tick;
    st_addr = 8'h80;
    tick;
    chk("arst_stat", st_dout, {m_ovf, 7'(q.size())});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
